// File: rtl/noc_link_arbiter.sv
// Packet-atomic round-robin arbiter that shares one registered flit link among N_IN senders.
// Valid/ready: a flit moves on a rising edge only when valid and ready are both high; ready may depend on valid.
module noc_link_arbiter #(
    parameter int N_IN   = 4,
    parameter int FLIT_W = 64,
    parameter int VC_NUM = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         in_valid_i,
    output logic [N_IN-1:0]         in_ready_o,
    input  logic [N_IN*FLIT_W-1:0]  in_flit_i,
    output logic [N_IN*VC_NUM-1:0]  in_vc_ready_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [FLIT_W-1:0]       out_flit_o,
    input  logic [VC_NUM-1:0]       out_vc_ready_i,
    output logic [$clog2(N_IN)-1:0] owner_o,
    output logic                    busy_o,
    output logic                    proto_err_o,
    output logic [$clog2(N_IN)-1:0] rr_ptr_o
);
    localparam int PW = $clog2(N_IN);
    localparam logic [1:0] TY_HEAD   = 2'b00;
    localparam logic [1:0] TY_BODY   = 2'b01;
    localparam logic [1:0] TY_TAIL   = 2'b10;
    localparam logic [1:0] TY_SINGLE = 2'b11;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic              out_valid_q, out_valid_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic              proto_err_q, proto_err_d;

    logic              stage_free;
    logic [N_IN-1:0]   is_start, is_cont;
    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     sel_idx;
    logic              sel_ok;
    logic [FLIT_W-1:0] sel_flit;
    logic [1:0]        sel_type;
    logic              accept;

    assign stage_free    = !out_valid_q || out_ready_i;
    assign in_vc_ready_o = {N_IN{out_vc_ready_i}};

    always_comb begin
        is_start = '0;
        is_cont  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_valid_i[i]) begin
                is_start[i] = in_flit_i[i*FLIT_W + FLIT_W-2 +: 2] inside {TY_HEAD, TY_SINGLE};
                is_cont[i]  = in_flit_i[i*FLIT_W + FLIT_W-2 +: 2] inside {TY_BODY, TY_TAIL};
            end
        end
    end

    // First packet start found scanning upward from rr_ptr, wrapping at N_IN.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (!win_found && is_start[(int'(rr_ptr_q) + k) % N_IN]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(rr_ptr_q) + k) % N_IN);
            end
        end
    end

    assign sel_idx  = (state_q == ST_LOCKED) ? owner_q : win_idx;
    assign sel_ok   = (state_q == ST_LOCKED) || win_found;
    assign sel_flit = in_flit_i[sel_idx*FLIT_W +: FLIT_W];
    assign sel_type = sel_flit[FLIT_W-1 -: 2];
    assign accept   = |(in_valid_i & in_ready_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && sel_type == TY_HEAD) state_d = ST_LOCKED;
            ST_LOCKED: if (accept && sel_type == TY_TAIL) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = '0;
        if (sel_ok && stage_free) in_ready_o[sel_idx] = 1'b1;
        busy_o = (state_q == ST_LOCKED);
    end

    // A HEAD/SINGLE from the lock owner is still forwarded; it only raises the error flag.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        proto_err_d = proto_err_q;
        if (state_q == ST_IDLE && |is_cont) proto_err_d = 1'b1;
        if (accept) begin
            out_valid_d = 1'b1;
            out_flit_d  = sel_flit;
            if (state_q == ST_IDLE) begin
                owner_d  = win_idx;
                rr_ptr_d = (win_idx == PW'(N_IN-1)) ? '0 : win_idx + 1'b1;
            end else if (sel_type inside {TY_HEAD, TY_SINGLE}) begin
                proto_err_d = 1'b1;
            end
        end else if (stage_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_flit_o  = out_flit_q;
    assign owner_o     = owner_q;
    assign proto_err_o = proto_err_q;
    assign rr_ptr_o    = rr_ptr_q;

endmodule
